vga_timing_gen: RTL and testbench

- Generates raster scan coordinates and sync timing for 640x480@60 from the 50 MHz system clock.
- Drives DrawX, DrawY and blank into color_mapper, which consumes them.
- Drives hs, vs and pixel_clk to the VGA DAC, and vblank_start to game/sprite logic.
- Single clock domain; the pixel rate is an internal clock enable (Clk/2).

---
 rtl/vga_timing_gen.sv | 108 ++++++++++
 tb/tb_vga_timing_gen.sv | 324 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/vga_timing_gen.sv
// 640x480@60 raster timing: pixel enable at Clk/2, scan counters and a registered
// decode stage producing coordinates, blanking, syncs and a vertical-blank strobe.
module vga_timing_gen #(
  parameter int unsigned H_VISIBLE = 640,
  parameter int unsigned H_FP      = 16,
  parameter int unsigned H_SYNC    = 96,
  parameter int unsigned H_BP      = 48,
  parameter int unsigned V_VISIBLE = 480,
  parameter int unsigned V_FP      = 10,
  parameter int unsigned V_SYNC    = 2,
  parameter int unsigned V_BP      = 33
) (
  input  logic        Clk,
  input  logic        Reset_n,
  output logic        pixel_clk,
  output logic        hs,
  output logic        vs,
  output logic        blank,
  output logic [9:0]  DrawX,
  output logic [9:0]  DrawY,
  output logic        vblank_start
);

  localparam int unsigned CW      = 10;
  localparam int unsigned KW      = 11;
  localparam int unsigned H_TOTAL = H_VISIBLE + H_FP + H_SYNC + H_BP;
  localparam int unsigned V_TOTAL = V_VISIBLE + V_FP + V_SYNC + V_BP;

  if (H_TOTAL > 1024 || V_TOTAL > 1024) begin : g_bad_totals
    $error("vga_timing_gen: H_TOTAL and V_TOTAL must not exceed 1024");
  end

  localparam logic [CW-1:0] H_LAST   = CW'(H_TOTAL - 1);
  localparam logic [CW-1:0] V_LAST   = CW'(V_TOTAL - 1);
  localparam logic [CW-1:0] V_VIS_C  = CW'(V_VISIBLE);
  // Decode bounds are one bit wider so a boundary of exactly 1024 still compares correctly
  localparam logic [KW-1:0] H_VIS_K  = KW'(H_VISIBLE);
  localparam logic [KW-1:0] V_VIS_K  = KW'(V_VISIBLE);
  localparam logic [KW-1:0] H_SB_K   = KW'(H_VISIBLE + H_FP);
  localparam logic [KW-1:0] H_SE_K   = KW'(H_VISIBLE + H_FP + H_SYNC);
  localparam logic [KW-1:0] V_SB_K   = KW'(V_VISIBLE + V_FP);
  localparam logic [KW-1:0] V_SE_K   = KW'(V_VISIBLE + V_FP + V_SYNC);

  logic          pix_ce_q;
  logic [CW-1:0] hc_q, hc_d;
  logic [CW-1:0] vc_q, vc_d;
  logic [KW-1:0] hc_k, vc_k;
  logic          blank_d, hs_d, vs_d, vbs_d;
  logic          blank_q, hs_q, vs_q, vbs_q;
  logic [CW-1:0] drawx_q, drawy_q;

  // Scan counters advance only on pixel-enable cycles
  always_comb begin
    hc_d = hc_q;
    vc_d = vc_q;
    if (pix_ce_q) begin
      if (hc_q == H_LAST) begin
        hc_d = '0;
        vc_d = (vc_q == V_LAST) ? '0 : vc_q + CW'(1);
      end else begin
        hc_d = hc_q + CW'(1);
      end
    end
  end

  // Decode of the current counter position, registered one Clk later
  always_comb begin
    hc_k    = {1'b0, hc_q};
    vc_k    = {1'b0, vc_q};
    blank_d = (hc_k < H_VIS_K) && (vc_k < V_VIS_K);
    hs_d    = !((hc_k >= H_SB_K) && (hc_k < H_SE_K));
    vs_d    = !((vc_k >= V_SB_K) && (vc_k < V_SE_K));
    vbs_d   = (hc_q == '0) && (vc_q == V_VIS_C) && !pix_ce_q;
  end

  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      pix_ce_q <= 1'b0;
      hc_q     <= '0;
      vc_q     <= '0;
      blank_q  <= 1'b0;
      hs_q     <= 1'b1;
      vs_q     <= 1'b1;
      vbs_q    <= 1'b0;
      drawx_q  <= '0;
      drawy_q  <= '0;
    end else begin
      pix_ce_q <= ~pix_ce_q;
      hc_q     <= hc_d;
      vc_q     <= vc_d;
      blank_q  <= blank_d;
      hs_q     <= hs_d;
      vs_q     <= vs_d;
      vbs_q    <= vbs_d;
      drawx_q  <= hc_q;
      drawy_q  <= vc_q;
    end
  end

  assign pixel_clk    = pix_ce_q;
  assign hs           = hs_q;
  assign vs           = vs_q;
  assign blank        = blank_q;
  assign DrawX        = drawx_q;
  assign DrawY        = drawy_q;
  assign vblank_start = vbs_q;

endmodule

// File: tb/tb_vga_timing_gen.sv
// Directed bench for vga_timing_gen: full-size instance for line timing and reset,
// a shrunken instance (16x12 totals) so whole frames fit in a short run.
module tb_vga_timing_gen;

  logic Clk = 1'b0;
  logic Reset_n = 1'b0;
  int   n_checks = 0;
  int   n_fail = 0;

  always #5 Clk = ~Clk;

  logic       d_pclk, d_hs, d_vs, d_blank, d_vbs;
  logic [9:0] d_x, d_y;
  logic       s_pclk, s_hs, s_vs, s_blank, s_vbs;
  logic [9:0] s_x, s_y;

  vga_timing_gen u_dut (
    .Clk(Clk), .Reset_n(Reset_n), .pixel_clk(d_pclk), .hs(d_hs), .vs(d_vs),
    .blank(d_blank), .DrawX(d_x), .DrawY(d_y), .vblank_start(d_vbs)
  );

  // Small raster: H 8+2+3+3=16 (hs low at 10..12), V 6+2+2+2=12 (vs low at 8..9)
  vga_timing_gen #(
    .H_VISIBLE(8), .H_FP(2), .H_SYNC(3), .H_BP(3),
    .V_VISIBLE(6), .V_FP(2), .V_SYNC(2), .V_BP(2)
  ) u_small (
    .Clk(Clk), .Reset_n(Reset_n), .pixel_clk(s_pclk), .hs(s_hs), .vs(s_vs),
    .blank(s_blank), .DrawX(s_x), .DrawY(s_y), .vblank_start(s_vbs)
  );

  logic armed;
  always @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) armed <= 1'b0;
    else          armed <= 1'b1;
  end

  // Blank/coordinate invariants on every Clk once the first post-reset edge has occurred
  always @(negedge Clk) begin
    if (armed) begin
      n_checks++;
      if (d_blank !== ((d_x < 10'd640) && (d_y < 10'd480))) begin
        n_fail++;
        $display("FAIL blank_inv_full: blank=%0b x=%0d y=%0d", d_blank, d_x, d_y);
      end
      n_checks++;
      if (d_x > 10'd799 || d_y > 10'd524) begin
        n_fail++;
        $display("FAIL range_full: x=%0d y=%0d required x<=799 y<=524", d_x, d_y);
      end
      n_checks++;
      if (s_blank !== ((s_x < 10'd8) && (s_y < 10'd6))) begin
        n_fail++;
        $display("FAIL blank_inv_small: blank=%0b x=%0d y=%0d", s_blank, s_x, s_y);
      end
      n_checks++;
      if (s_x > 10'd15 || s_y > 10'd11) begin
        n_fail++;
        $display("FAIL range_small: x=%0d y=%0d required x<=15 y<=11", s_x, s_y);
      end
    end
  end

  task automatic tick();
    @(posedge Clk);
    #1;
  endtask

  task automatic test_reset();
    logic [24:0] got, exp_v;
    exp_v = {5'b01100, 20'd0};
    Reset_n = 1'b0;
    for (int i = 0; i < 5; i++) begin
      tick();
      got = {d_pclk, d_hs, d_vs, d_blank, d_vbs, d_x, d_y};
      n_checks++;
      if (got !== exp_v) begin
        n_fail++;
        $display("FAIL reset_hold_full: got %h expected %h", got, exp_v);
      end
      got = {s_pclk, s_hs, s_vs, s_blank, s_vbs, s_x, s_y};
      n_checks++;
      if (got !== exp_v) begin
        n_fail++;
        $display("FAIL reset_hold_small: got %h expected %h", got, exp_v);
      end
    end
    @(negedge Clk);
    Reset_n = 1'b1;
    tick();
    n_checks++;
    if ({d_pclk, d_blank, d_x, d_y} !== {2'b11, 20'd0}) begin
      n_fail++;
      $display("FAIL release_edge1: pclk=%0b blank=%0b x=%0d y=%0d expected 1 1 0 0",
               d_pclk, d_blank, d_x, d_y);
    end
    n_checks++;
    if ({s_blank, s_x, s_y} !== {1'b1, 20'd0}) begin
      n_fail++;
      $display("FAIL release_edge1_small: blank=%0b x=%0d y=%0d expected 1 0 0", s_blank, s_x, s_y);
    end
    tick();
    n_checks++;
    if ({d_pclk, d_x} !== {1'b0, 10'd0}) begin
      n_fail++;
      $display("FAIL release_edge2: pclk=%0b x=%0d expected 0 0", d_pclk, d_x);
    end
    tick();
    n_checks++;
    if (d_x !== 10'd1) begin
      n_fail++;
      $display("FAIL release_edge3: x=%0d expected 1", d_x);
    end
  endtask

  task automatic test_line();
    logic [9:0] prev_x, prev_y, exp_x;
    logic       prev_hs;
    int         hold, lowc;
    bit         saw_fall, saw_rise, saw_wrap;
    saw_fall = 0; saw_rise = 0; saw_wrap = 0; lowc = 0;
    prev_x = d_x;
    for (int i = 0; i < 8 && d_x == prev_x; i++) tick();
    n_checks++;
    if (d_x == prev_x) begin
      n_fail++;
      $display("FAIL line_align: DrawX stuck at %0d", d_x);
      return;
    end
    hold = 1; prev_x = d_x; prev_y = d_y; prev_hs = d_hs;
    for (int i = 0; i < 1700; i++) begin
      tick();
      if (d_x != prev_x) begin
        n_checks++;
        if (hold !== 2) begin
          n_fail++;
          $display("FAIL x_hold: DrawX=%0d held %0d Clk expected 2", prev_x, hold);
        end
        exp_x = (prev_x == 10'd799) ? 10'd0 : prev_x + 10'd1;
        n_checks++;
        if (d_x !== exp_x) begin
          n_fail++;
          $display("FAIL x_step: got %0d expected %0d", d_x, exp_x);
        end
        if (d_x == 10'd0) begin
          saw_wrap = 1;
          n_checks++;
          if (d_y !== prev_y + 10'd1) begin
            n_fail++;
            $display("FAIL y_step: got %0d expected %0d", d_y, prev_y + 10'd1);
          end
        end
        if (d_x == 10'd639 || d_x == 10'd640) begin
          n_checks++;
          if (d_blank !== (d_x == 10'd639)) begin
            n_fail++;
            $display("FAIL blank_edge: x=%0d blank=%0b", d_x, d_blank);
          end
        end
        hold = 1;
      end else begin
        hold++;
      end
      if (prev_hs && !d_hs) begin
        saw_fall = 1;
        lowc = 0;
        n_checks++;
        if (d_x !== 10'd656) begin
          n_fail++;
          $display("FAIL hs_fall: at DrawX=%0d expected 656", d_x);
        end
      end
      if (!d_hs) lowc++;
      if (!prev_hs && d_hs) begin
        n_checks++;
        if (d_x !== 10'd752) begin
          n_fail++;
          $display("FAIL hs_rise: at DrawX=%0d expected 752", d_x);
        end
        if (saw_fall) begin
          saw_rise = 1;
          n_checks++;
          if (lowc !== 192) begin
            n_fail++;
            $display("FAIL hs_low_len: got %0d Clk expected 192", lowc);
          end
        end
      end
      prev_x = d_x; prev_y = d_y; prev_hs = d_hs;
    end
    n_checks++;
    if (!(saw_fall && saw_rise && saw_wrap)) begin
      n_fail++;
      $display("FAIL line_events: fall=%0b rise=%0b wrap=%0b expected all 1",
               saw_fall, saw_rise, saw_wrap);
    end
  endtask

  task automatic test_frame();
    logic [9:0] prev_x, prev_y;
    logic       prev_vs, prev_vbs;
    int         last_fall, last_vb, n_falls, n_vb, vslow;
    last_fall = -1; last_vb = -1; n_falls = 0; n_vb = 0; vslow = 0;
    prev_x = s_x; prev_y = s_y; prev_vs = s_vs; prev_vbs = s_vbs;
    for (int cyc = 0; cyc < 1200; cyc++) begin
      tick();
      n_checks++;
      if (s_vs !== !(s_y == 10'd8 || s_y == 10'd9)) begin
        n_fail++;
        $display("FAIL vs_window: vs=%0b at DrawY=%0d", s_vs, s_y);
      end
      if (prev_vs && !s_vs) begin
        vslow = 0;
        if (last_fall >= 0) begin
          n_checks++;
          if (cyc - last_fall !== 384) begin
            n_fail++;
            $display("FAIL vs_period: got %0d Clk expected 384", cyc - last_fall);
          end
        end
        last_fall = cyc;
        n_falls++;
      end
      if (!s_vs) vslow++;
      if (!prev_vs && s_vs && n_falls > 0) begin
        n_checks++;
        if (vslow !== 64) begin
          n_fail++;
          $display("FAIL vs_low_len: got %0d Clk expected 64", vslow);
        end
      end
      if (s_y == 10'd6 && prev_y == 10'd5) begin
        n_checks++;
        if (s_vbs !== 1'b1 || s_x !== 10'd0) begin
          n_fail++;
          $display("FAIL vblank_missing: vbs=%0b x=%0d at first Clk of DrawY=6", s_vbs, s_x);
        end
      end
      if (s_vbs) begin
        n_checks++;
        if (prev_vbs || !(s_y == 10'd6 && prev_y == 10'd5 && s_x == 10'd0)) begin
          n_fail++;
          $display("FAIL vblank_place: prev=%0b x=%0d y=%0d prev_y=%0d", prev_vbs, s_x, s_y, prev_y);
        end
        if (last_vb >= 0) begin
          n_checks++;
          if (cyc - last_vb !== 384) begin
            n_fail++;
            $display("FAIL vblank_period: got %0d Clk expected 384", cyc - last_vb);
          end
        end
        last_vb = cyc;
        n_vb++;
      end
      if (prev_y == 10'd11 && s_y == 10'd0) begin
        n_checks++;
        if ({prev_x, s_x} !== {10'd15, 10'd0}) begin
          n_fail++;
          $display("FAIL frame_wrap: x %0d->%0d expected 15->0", prev_x, s_x);
        end
        n_checks++;
        if ({s_blank, s_hs, s_vs} !== 3'b111) begin
          n_fail++;
          $display("FAIL wrap_decode: blank/hs/vs=%b expected 111", {s_blank, s_hs, s_vs});
        end
      end
      prev_x = s_x; prev_y = s_y; prev_vs = s_vs; prev_vbs = s_vbs;
    end
    n_checks++;
    if (n_falls < 2 || n_vb < 2) begin
      n_fail++;
      $display("FAIL frame_events: vs falls=%0d vblank pulses=%0d expected >=2 each", n_falls, n_vb);
    end
  endtask

  task automatic test_mid_reset();
    logic [24:0] got, exp_v;
    exp_v = {5'b01100, 20'd0};
    for (int i = 0; i < 1700 && d_x != 10'd700; i++) tick();
    n_checks++;
    if (d_x !== 10'd700 || d_hs !== 1'b0) begin
      n_fail++;
      $display("FAIL mid_reset_setup: x=%0d hs=%0b expected 700 0", d_x, d_hs);
      return;
    end
    #2;
    Reset_n = 1'b0;
    #1;
    for (int i = 0; i < 3; i++) begin
      got = {d_pclk, d_hs, d_vs, d_blank, d_vbs, d_x, d_y};
      n_checks++;
      if (got !== exp_v) begin
        n_fail++;
        $display("FAIL mid_reset_full: got %h expected %h", got, exp_v);
      end
      got = {s_pclk, s_hs, s_vs, s_blank, s_vbs, s_x, s_y};
      n_checks++;
      if (got !== exp_v) begin
        n_fail++;
        $display("FAIL mid_reset_small: got %h expected %h", got, exp_v);
      end
      tick();
    end
    #3;
    Reset_n = 1'b1;
    tick();
    n_checks++;
    if ({d_blank, d_hs, d_x, d_y} !== {2'b11, 20'd0}) begin
      n_fail++;
      $display("FAIL mid_reset_release: blank=%0b hs=%0b x=%0d y=%0d expected 1 1 0 0",
               d_blank, d_hs, d_x, d_y);
    end
  endtask

  initial begin
    test_reset();
    test_line();
    test_frame();
    test_mid_reset();
    test_line();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
